enc_onehot2bin: RTL and testbench
=================================

# enc_onehot2bin

Registered one-hot to binary encoder with valid/ready handshaking on both sides and error accounting. It is the inverse of the binary-to-one-hot encoder: it takes a 15-bit one-hot vector, where bit i means value i, and returns the 4-bit index. Malformed vectors are flagged and counted. It sits on the return path of select/grant buses and drives a single-stage output register that supports backpressure.

## Interface
- WIDTH, 15, one-hot input width; bit i encodes value i
- BIN_W, 4, binary output width; must satisfy 2^BIN_W >= WIDTH
- CNT_W, 8, error counter width
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-low reset (asserted when 0)
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept a beat this cycle
- in  input  WIDTH  one-hot vector
- out_valid  output  1  output register holds a beat
- out_ready  input  1  downstream accepts the beat this cycle
- out  output  BIN_W  encoded index
- out_err  output  1  beat in the output register was malformed
- err_clr  input  1  synchronous clear of err_cnt
- err_cnt  output  CNT_W  saturating count of accepted malformed beats

## Operation
- Accept condition: in_valid && in_ready.
- in_ready = rst && (!out_valid || out_ready). This is combinational, with a pass-through path when the register is full and being drained. It is 0 while reset is asserted.
- On accept, the output register loads {out, out_err} from in and out_valid is set. On the same edge as an accept, a drain (out_valid && out_ready) is replaced by the new beat.
- A drain with no accept clears out_valid. out and out_err keep their last values.
- While out_valid && !out_ready, out, out_err and out_valid hold stable.
- Decode rules:
  - Exactly one bit i set: out=i, out_err=0.
  - Zero bits set: out=0, out_err=1.
  - Multiple bits set: behaviour depends on configuration (see below).
- err_cnt increments by 1 on each accepted beat whose decoded out_err=1. It saturates at 2^CNT_W-1 and does not wrap.
- err_clr=1 sets err_cnt to 0 on the next edge. It takes priority over a coincident increment, so that error is not counted.
- Input bits above WIDTH-1 do not exist. Indices WIDTH..2^BIN_W-1 are never produced.

## Timing
- Reset (rst=0 at an edge): out_valid=0, out=0, out_err=0, err_cnt=0. in_ready=0 during reset, and 1 on the first cycle after release.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 beat/cycle while out_ready=1.
- Reset asserted mid-transfer discards the held beat. No partial state survives.
- err_cnt updates on the same edge as the accept of the erroneous beat. It is visible one cycle later, coincident with out_valid for that beat.

## Configuration
- ONEHOT2BIN_STRICT_EN defined: multi-hot input gives out=0 and out_err=1, and is counted in err_cnt.
- ONEHOT2BIN_STRICT_EN undefined: multi-hot input is priority-encoded to the lowest set index with out_err=0, and is not counted. Zero-hot input is still an error in both modes.

## Test plan
- Reset, then sweep in=1<<i for i=0..14 with out_ready=1 -> out=i one cycle after each accept, out_err=0, err_cnt=0.
- in=15'h0000 accepted -> out=0, out_err=1, err_cnt=1. Then err_clr=1 together with another zero-hot accept -> err_cnt=0.
- in=15'h0024 (bits 2 and 5) -> strict build: out=0, out_err=1, err_cnt+1. Non-strict build: out=2, out_err=0, err_cnt unchanged.
- Backpressure: accept in=15'h0100, hold out_ready=0 for 3 cycles with in_valid=1 and in=15'h0002 -> in_ready=0 and out=8 stable. Raise out_ready -> out=8 drains while the 15'h0002 beat is accepted on the same edge, and out=1 appears the next cycle.
- Saturation: 260 accepted zero-hot beats -> err_cnt=255, no wrap.
- Reset with out_valid=1 and out_ready=0 -> next cycle out_valid=0, out=0, out_err=0, err_cnt=0.

Source files
------------

// File: rtl/enc_onehot2bin.sv
// Registered one-hot to binary encoder with valid/ready on both sides and a saturating error counter.
// Define ONEHOT2BIN_STRICT_EN to treat multi-hot input as an error; otherwise it priority-encodes to the lowest set bit.
module enc_onehot2bin #(
    parameter int WIDTH = 15,
    parameter int BIN_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BIN_W-1:0] out,
    output logic             out_err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_cnt
);

    // Handshake: a beat transfers on any rising edge where valid && ready are both 1.
    // in_ready depends combinationally on out_ready so a full register can be
    // drained and refilled on the same edge; it is held low during reset.

    logic [BIN_W-1:0] dec_idx;
    logic [BIN_W-1:0] dec_bin;
    logic             dec_zero;
    logic             dec_err;
    logic             in_accept;

    // Scanning downward leaves the lowest set index in dec_idx.
    always_comb begin
        dec_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (in[i]) begin
                dec_idx = BIN_W'(i);
            end
        end
    end

    assign dec_zero = (in == '0);

`ifdef ONEHOT2BIN_STRICT_EN
    logic dec_multi;
    assign dec_multi = |(in & (in - WIDTH'(1)));
    assign dec_err   = dec_zero | dec_multi;
    assign dec_bin   = dec_err ? '0 : dec_idx;
`else
    assign dec_err   = dec_zero;
    assign dec_bin   = dec_idx;
`endif

    assign in_ready  = rst && (!out_valid || out_ready);
    assign in_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out       <= '0;
            out_err   <= 1'b0;
        end else if (in_accept) begin
            out_valid <= 1'b1;
            out       <= dec_bin;
            out_err   <= dec_err;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Clear wins over a coincident increment; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (in_accept && dec_err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_enc_onehot2bin.sv
// Bench for enc_onehot2bin: directed vectors, expected beats queued by the driver
// and popped by a monitor whenever the output register drains.
module tb_enc_onehot2bin;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic        out_err;
    logic        err_clr;
    logic [7:0]  err_cnt;

    logic [4:0]  exp_q[$];
    int          vectors;
    int          miscompares;

    enc_onehot2bin dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_data),
        .out_err   (out_err),
        .err_clr   (err_clr),
        .err_cnt   (err_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drivers run in the phase just after a rising edge.
    task automatic send(input logic [14:0] v, input logic [3:0] e_bin, input logic e_err);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = v;
        #1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
        end else begin
            exp_q.push_back({e_bin, e_err});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // scoreboard monitor: a beat is consumed when out_valid && out_ready before an edge
    initial begin
        logic [4:0] e;
        forever begin
            @(negedge clk);
            if (rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out", int'(out_data), int'(e[4:1]));
                    chk("out_err", int'(out_err), int'(e[0]));
                end
            end
        end
    end

    initial begin
        int start_cnt;
        int exp_cnt;
        vectors     = 0;
        miscompares = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        err_clr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out", int'(out_data), 0);
        chk("rst_out_err", int'(out_err), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        rst = 1'b1;
        #1;
        chk("in_ready_after_rst", int'(in_ready), 1);

        // one-hot sweep, back to back
        for (int i = 0; i < 15; i++) begin
            logic [14:0] v;
            v = 15'(1) << i;
            send(v, 4'(i), 1'b0);
            chk("sweep_err_cnt", int'(err_cnt), 0);
        end

        // zero-hot, then clear coincident with another zero-hot accept
        send(15'h0000, 4'd0, 1'b1);
        chk("zero_err_cnt", int'(err_cnt), 1);
        err_clr = 1'b1;
        send(15'h0000, 4'd0, 1'b1);
        err_clr = 1'b0;
        chk("clr_err_cnt", int'(err_cnt), 0);

        // multi-hot
`ifdef ONEHOT2BIN_STRICT_EN
        send(15'h0024, 4'd0, 1'b1);
        chk("multi_err_cnt", int'(err_cnt), 1);
        start_cnt = 1;
`else
        send(15'h0024, 4'd2, 1'b0);
        chk("multi_err_cnt", int'(err_cnt), 0);
        start_cnt = 0;
`endif
        idle(1);

        // backpressure with pass-through refill
        out_ready = 1'b0;
        send(15'h0100, 4'd8, 1'b0);
        in_valid = 1'b1;
        in_data  = 15'h0002;
        repeat (3) begin
            #1;
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_out", int'(out_data), 8);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_pass_ready", int'(in_ready), 1);
        exp_q.push_back({4'd1, 1'b0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_refill_out", int'(out_data), 1);
        chk("bp_refill_valid", int'(out_valid), 1);
        idle(1);

        // saturation
        exp_cnt = start_cnt;
        for (int i = 0; i < 260; i++) begin
            send(15'h0000, 4'd0, 1'b1);
            if (exp_cnt < 255) exp_cnt++;
            if (i == 100) chk("sat_mid_err_cnt", int'(err_cnt), exp_cnt);
        end
        chk("sat_err_cnt", int'(err_cnt), 255);
        idle(2);

        // reset while a beat is held under backpressure
        out_ready = 1'b0;
        send(15'h0004, 4'd2, 1'b1 ^ 1'b1);
        chk("held_valid", int'(out_valid), 1);
        rst = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_out", int'(out_data), 0);
        chk("mid_rst_out_err", int'(out_err), 0);
        chk("mid_rst_err_cnt", int'(err_cnt), 0);
        chk("mid_rst_in_ready", int'(in_ready), 0);
        rst = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("post_rst_in_ready", int'(in_ready), 1);
        send(15'h4000, 4'd14, 1'b0);
        idle(3);
        chk("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
